// File: rtl/myooo_inst_buffer.sv
// Instruction buffer between fetch and dispatch: a circular FIFO that compacts sparse
// fetch lanes on write and offers up to DISP_SIZE oldest instructions per cycle.
module myooo_inst_buffer #(
    parameter int unsigned ENTRY_SIZE = 6,
    parameter int unsigned FETCH_W    = 2,
    parameter int unsigned DISP_SIZE  = 2,
    parameter int unsigned PC_W       = 39
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_flush,

    input  logic                              i_fetch_valid,
    input  logic [FETCH_W-1:0]                i_fetch_lane_valid,
    input  logic [PC_W-1:0]                   i_fetch_pc,
    input  logic [FETCH_W*32-1:0]             i_fetch_inst,
    output logic                              o_fetch_ready,

    output logic                              o_disp_valid,
    output logic [DISP_SIZE-1:0]              o_disp_lane_valid,
    output logic [DISP_SIZE*32-1:0]           o_disp_inst,
    output logic [DISP_SIZE*PC_W-1:0]         o_disp_pc,
    input  logic                              i_disp_ready,

    output logic [$clog2(ENTRY_SIZE+1)-1:0]   o_count
);

    localparam int unsigned CNT_W = $clog2(ENTRY_SIZE + 1);
    localparam int unsigned PTR_W = $clog2(ENTRY_SIZE);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      inst_q [ENTRY_SIZE];
    logic [PC_W-1:0]  pc_q   [ENTRY_SIZE];

    logic             fetch_ready;
    logic             enq_fire;
    logic             deq_fire;
    logic [DISP_SIZE-1:0] disp_lane_valid;
    int unsigned      enq_n;
    int unsigned      deq_n;
    logic [PTR_W-1:0] wr_idx [FETCH_W];

    // Pointer arithmetic modulo a depth that need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned off);
        int unsigned sum;
        sum = (32'(ptr) + off) % ENTRY_SIZE;
        return PTR_W'(sum);
    endfunction

    // Valid lanes are packed: each lane lands at tail + (number of valid lanes below it).
    always_comb begin
        enq_n = 0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            wr_idx[i] = ptr_add(tail_q, enq_n);
            if (i_fetch_lane_valid[i]) begin
                enq_n = enq_n + 1;
            end
        end
    end

    always_comb begin
        fetch_ready = (ENTRY_SIZE - 32'(count_q)) >= FETCH_W;
        enq_fire    = i_fetch_valid & fetch_ready & ~i_flush;

        for (int unsigned k = 0; k < DISP_SIZE; k++) begin
            disp_lane_valid[k] = 32'(count_q) > k;
        end
        deq_n    = (32'(count_q) < DISP_SIZE) ? 32'(count_q) : DISP_SIZE;
        deq_fire = (|disp_lane_valid) & i_disp_ready & ~i_flush;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d = ptr_add(tail_q, enq_n);
            end
            if (deq_fire) begin
                head_d = ptr_add(head_q, deq_n);
            end
            count_d = CNT_W'(32'(count_q) + (enq_fire ? enq_n : 0) - (deq_fire ? deq_n : 0));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; only the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            if (!i_reset && enq_fire && i_fetch_lane_valid[i]) begin
                inst_q[wr_idx[i]] <= i_fetch_inst[32*i +: 32];
                pc_q[wr_idx[i]]   <= i_fetch_pc + PC_W'(4 * i);
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < DISP_SIZE; k++) begin
            o_disp_inst[32*k +: 32]   = inst_q[ptr_add(head_q, k)];
            o_disp_pc[PC_W*k +: PC_W] = pc_q[ptr_add(head_q, k)];
        end
    end

    assign o_fetch_ready     = fetch_ready;
    assign o_disp_lane_valid = disp_lane_valid;
    assign o_disp_valid      = |disp_lane_valid;
    assign o_count           = count_q;

endmodule

// File: tb/tb_myooo_inst_buffer.sv
// Scoreboard bench for myooo_inst_buffer: a queue model of the buffered program-order
// stream is compared every cycle against the dispatch outputs, count and fetch_ready.
module tb_myooo_inst_buffer;

    localparam int unsigned ENTRY_SIZE = 6;
    localparam int unsigned FETCH_W    = 2;
    localparam int unsigned DISP_SIZE  = 2;
    localparam int unsigned PC_W       = 39;

    logic                          i_clk;
    logic                          i_reset;
    logic                          i_flush;
    logic                          i_fetch_valid;
    logic [FETCH_W-1:0]            i_fetch_lane_valid;
    logic [PC_W-1:0]               i_fetch_pc;
    logic [FETCH_W*32-1:0]         i_fetch_inst;
    logic                          o_fetch_ready;
    logic                          o_disp_valid;
    logic [DISP_SIZE-1:0]          o_disp_lane_valid;
    logic [DISP_SIZE*32-1:0]       o_disp_inst;
    logic [DISP_SIZE*PC_W-1:0]     o_disp_pc;
    logic                          i_disp_ready;
    logic [$clog2(ENTRY_SIZE+1)-1:0] o_count;

    myooo_inst_buffer #(
        .ENTRY_SIZE (ENTRY_SIZE),
        .FETCH_W    (FETCH_W),
        .DISP_SIZE  (DISP_SIZE),
        .PC_W       (PC_W)
    ) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_flush            (i_flush),
        .i_fetch_valid      (i_fetch_valid),
        .i_fetch_lane_valid (i_fetch_lane_valid),
        .i_fetch_pc         (i_fetch_pc),
        .i_fetch_inst       (i_fetch_inst),
        .o_fetch_ready      (o_fetch_ready),
        .o_disp_valid       (o_disp_valid),
        .o_disp_lane_valid  (o_disp_lane_valid),
        .o_disp_inst        (o_disp_inst),
        .o_disp_pc          (o_disp_pc),
        .i_disp_ready       (i_disp_ready),
        .o_count            (o_count)
    );

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just an ordered list of (pc, inst) in program order.
    int unsigned m_sz;
    int unsigned m_deq;
    bit          m_acc;
    ent_t        m_e;
    always @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            exp_q.delete();
        end else begin
            m_sz  = exp_q.size();
            m_acc = i_fetch_valid && (ENTRY_SIZE - m_sz >= FETCH_W);
            if (i_disp_ready) begin
                m_deq = (m_sz < DISP_SIZE) ? m_sz : DISP_SIZE;
                repeat (m_deq) void'(exp_q.pop_front());
            end
            if (m_acc) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    if (i_fetch_lane_valid[i]) begin
                        m_e.pc   = i_fetch_pc + PC_W'(4 * i);
                        m_e.inst = i_fetch_inst[32*i +: 32];
                        exp_q.push_back(m_e);
                    end
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the head of the model queue.
    int unsigned          mon_n;
    logic [DISP_SIZE-1:0] mon_mask;
    always @(negedge i_clk) begin
        if (mon_en) begin
            mon_n = exp_q.size();
            chk("count", 64'(o_count), 64'(mon_n));
            chk("fetch_ready", 64'(o_fetch_ready), 64'(ENTRY_SIZE - mon_n >= FETCH_W));
            chk("disp_valid", 64'(o_disp_valid), 64'(mon_n > 0));
            for (int k = 0; k < DISP_SIZE; k++) mon_mask[k] = mon_n > k;
            chk("lane_mask", 64'(o_disp_lane_valid), 64'(mon_mask));
            for (int k = 0; k < DISP_SIZE; k++) begin
                if (mon_n > k) begin
                    chk("lane_inst", 64'(o_disp_inst[32*k +: 32]), 64'(exp_q[k].inst));
                    chk("lane_pc", 64'(o_disp_pc[PC_W*k +: PC_W]), 64'(exp_q[k].pc));
                end
            end
        end
    end

    task automatic drive(input logic fv, input logic [FETCH_W-1:0] mask,
                         input logic [PC_W-1:0] pc, input logic [FETCH_W*32-1:0] inst,
                         input logic dr, input logic fl);
        i_fetch_valid      = fv;
        i_fetch_lane_valid = mask;
        i_fetch_pc         = pc;
        i_fetch_inst       = inst;
        i_disp_ready       = dr;
        i_flush            = fl;
        @(posedge i_clk);
        #1;
    endtask

    logic [63:0]     rnd;
    logic [PC_W-1:0] rpc;

    initial begin
        i_reset = 1'b1;
        drive(0, '0, '0, '0, 0, 0);
        drive(0, '0, '0, '0, 0, 0);
        i_reset = 1'b0;
        mon_en  = 1;
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_disp_valid", 64'(o_disp_valid), 64'd0);
        chk("rst_lane_mask", 64'(o_disp_lane_valid), 64'd0);
        chk("rst_fetch_ready", 64'(o_fetch_ready), 64'd1);

        // Full beat: A then B, consecutive PCs
        drive(1, 2'b11, 39'h1000, {32'hBBBB0002, 32'hAAAA0001}, 0, 0);
        chk("d1_mask", 64'(o_disp_lane_valid), 64'h3);
        chk("d1_inst0", 64'(o_disp_inst[31:0]), 64'hAAAA0001);
        chk("d1_pc0", 64'(o_disp_pc[PC_W-1:0]), 64'h1000);
        chk("d1_inst1", 64'(o_disp_inst[63:32]), 64'hBBBB0002);
        chk("d1_pc1", 64'(o_disp_pc[2*PC_W-1:PC_W]), 64'h1004);
        chk("d1_count", 64'(o_count), 64'd2);
        drive(0, '0, '0, '0, 0, 1);

        // Sparse beat: only lane 1
        drive(1, 2'b10, 39'h2000, {32'hCCCC0003, 32'hDDDD0004}, 0, 0);
        chk("d2_count", 64'(o_count), 64'd1);
        chk("d2_mask", 64'(o_disp_lane_valid), 64'h1);
        chk("d2_inst0", 64'(o_disp_inst[31:0]), 64'hCCCC0003);
        chk("d2_pc0", 64'(o_disp_pc[PC_W-1:0]), 64'h2004);
        drive(0, '0, '0, '0, 0, 1);

        // Fill to 5 with dispatch stalled
        drive(1, 2'b11, 39'h3000, {32'h31, 32'h30}, 0, 0);
        drive(1, 2'b11, 39'h3100, {32'h33, 32'h32}, 0, 0);
        drive(1, 2'b01, 39'h3200, {32'h35, 32'h34}, 0, 0);
        chk("d3_count5", 64'(o_count), 64'd5);
        chk("d3_not_ready", 64'(o_fetch_ready), 64'd0);
        drive(0, '0, '0, '0, 1, 0);
        chk("d3_count3", 64'(o_count), 64'd3);
        chk("d3_ready", 64'(o_fetch_ready), 64'd1);
        chk("d3_pc0", 64'(o_disp_pc[PC_W-1:0]), 64'h3100);

        // Count 4, simultaneous 2-in / 2-out
        drive(1, 2'b01, 39'h3300, {32'h37, 32'h36}, 0, 0);
        chk("d4_count4", 64'(o_count), 64'd4);
        drive(1, 2'b11, 39'h3400, {32'h39, 32'h38}, 1, 0);
        chk("d4_count", 64'(o_count), 64'd4);
        chk("d4_pc0", 64'(o_disp_pc[PC_W-1:0]), 64'h3200);
        chk("d4_pc1", 64'(o_disp_pc[2*PC_W-1:PC_W]), 64'h3300);
        drive(0, '0, '0, '0, 0, 1);

        // Streaming 2 in / 2 out across pointer wrap
        for (int c = 0; c < 20; c++) begin
            drive(1, 2'b11, PC_W'(32'h4000 + 8 * c), {32'(2 * c + 1), 32'(2 * c)}, 1, 0);
            chk("st_count", 64'(o_count), 64'd2);
            chk("st_pc0", 64'(o_disp_pc[PC_W-1:0]), 64'(32'h4000 + 8 * c));
            chk("st_pc1", 64'(o_disp_pc[2*PC_W-1:PC_W]), 64'(32'h4004 + 8 * c));
        end
        drive(0, '0, '0, '0, 0, 1);

        // Flush beats simultaneous fetch and dispatch at count 3
        drive(1, 2'b11, 39'h5000, {32'h51, 32'h50}, 0, 0);
        drive(1, 2'b01, 39'h5100, {32'h53, 32'h52}, 0, 0);
        chk("fl_pre_count", 64'(o_count), 64'd3);
        drive(1, 2'b11, 39'h5200, {32'h55, 32'h54}, 1, 1);
        chk("fl_count", 64'(o_count), 64'd0);
        chk("fl_disp_valid", 64'(o_disp_valid), 64'd0);
        drive(0, '0, '0, '0, 1, 0);
        chk("fl_idle_count", 64'(o_count), 64'd0);

        // Random traffic, including PC wrap at 2^PC_W, flushes and resets
        for (int r = 0; r < 600; r++) begin
            rnd = {$urandom(), $urandom()};
            rpc = rnd[PC_W-1:0];
            if ($urandom_range(0, 7) == 0) begin
                rpc = '1;
                rpc = rpc - PC_W'(1);
            end
            i_reset = ($urandom_range(0, 150) == 0);
            drive($urandom_range(0, 3) != 0, FETCH_W'($urandom_range(0, 3)), rpc,
                  {$urandom(), $urandom()}, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0);
        end
        i_reset = 1'b0;
        drive(0, '0, '0, '0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/myooo_inst_buffer.md
MYOOO_INST_BUFFER -- requirements
Module: myooo_inst_buffer

Interface
REQ-001 SHALL have parameter ENTRY_SIZE, default 6, the number of instruction entries (any value 4..16, not required to be a power of two).
REQ-002 SHALL have parameter FETCH_W, default 2, the number of instruction lanes per fetch beat.
REQ-003 SHALL have parameter DISP_SIZE, default 2, the number of instruction lanes per dispatch beat.
REQ-004 SHALL have parameter PC_W, default 39, the PC width in bits.
REQ-005 SHALL have i_clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 SHALL have i_reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have i_flush, input, 1: discards all buffered instructions.
REQ-008 SHALL have i_fetch_valid, input, 1: fetch beat present.
REQ-009 SHALL have i_fetch_lane_valid, input, FETCH_W: per-lane valid mask; lanes need not be contiguous.
REQ-010 SHALL have i_fetch_pc, input, PC_W: PC of lane 0.
REQ-011 SHALL have i_fetch_inst, input, FETCH_W*32: lane i occupies bits [32i+31:32i].
REQ-012 SHALL have o_fetch_ready, output, 1: beat will be accepted.
REQ-013 SHALL have o_disp_valid, output, 1: at least one instruction offered.
REQ-014 SHALL have o_disp_lane_valid, output, DISP_SIZE: thermometer mask of offered lanes.
REQ-015 SHALL have o_disp_inst, output, DISP_SIZE*32: instructions, oldest in lane 0.
REQ-016 SHALL have o_disp_pc, output, DISP_SIZE*PC_W: PC per lane.
REQ-017 SHALL have i_disp_ready, input, 1: dispatch consumes all offered lanes.
REQ-018 SHALL have o_count, output, $clog2(ENTRY_SIZE+1): current occupancy.

Function
REQ-019 SHALL be a circular FIFO with head pointer, tail pointer and count; pointers SHALL wrap from ENTRY_SIZE-1 to 0.
REQ-020 SHALL drive o_fetch_ready = 1 iff (ENTRY_SIZE - count) >= FETCH_W, based only on registered state.
REQ-021 SHALL accept a beat when i_fetch_valid & o_fetch_ready & !i_flush, and SHALL ignore a beat with an all-zero lane mask.
REQ-022 SHALL compact the valid lanes of an accepted beat in ascending lane order into consecutive entries starting at the tail.
REQ-023 SHALL store, for lane i, PC = i_fetch_pc + 4*i, computed modulo 2^PC_W.
REQ-024 SHALL advance the tail and count by popcount(i_fetch_lane_valid) on acceptance.
REQ-025 SHALL drive o_disp_lane_valid lane k = 1 iff count > k; o_disp_valid SHALL equal the OR of that mask.
REQ-026 SHALL drive o_disp_inst and o_disp_pc lane k from entry (head+k) mod ENTRY_SIZE; lanes not valid are don't-care.
REQ-027 SHALL have no bypass path: an accepted instruction first appears on the dispatch outputs the cycle after acceptance.
REQ-028 SHALL, when o_disp_valid & i_disp_ready & !i_flush, advance the head by popcount(o_disp_lane_valid) and decrement count by the same amount.
REQ-029 SHALL apply enqueue and dequeue in the same cycle: count_next = count + enq_n - deq_n.
REQ-030 SHALL, on i_flush, set head = tail = count = 0 next cycle; flush has priority over simultaneous enqueue and dequeue.
REQ-031 SHALL never overflow or underflow; count SHALL stay in 0..ENTRY_SIZE.
REQ-032 SHALL keep output ordering strictly in program order across pointer wrap-around.

Reset
REQ-033 SHALL, on i_reset, set head = 0, tail = 0, count = 0 next edge, giving o_disp_valid = 0, o_disp_lane_valid = 0, o_count = 0 and o_fetch_ready = 1; i_reset has priority over i_flush and all traffic.
REQ-034 SHALL not reset entry storage; entry contents are don't-care while invalid.

Verification
REQ-035 SHALL be verified by this directed scenario: after reset, enqueue mask 2'b11, pc 0x1000, inst {B,A} -> the next cycle o_disp_lane_valid = 2'b11, lane 0 = A@0x1000, lane 1 = B@0x1004, o_count = 2.
REQ-036 SHALL be verified by this directed scenario: enqueue mask 2'b10, pc 0x2000 -> a single entry holding lane 1 at 0x2004, o_disp_lane_valid = 2'b01.
REQ-037 SHALL be verified by this directed scenario: fill to 5 entries with i_disp_ready held low -> o_fetch_ready = 0; a single dequeue of 2 -> o_count = 3 and o_fetch_ready = 1.
REQ-038 SHALL be verified by this directed scenario: with count 4, a simultaneous 2-lane enqueue and 2-lane dequeue -> o_count remains 4 and the head advances by 2.
REQ-039 SHALL be verified by this directed scenario: 20 cycles of continuous streaming at 2 in / 2 out -> the PC sequence is contiguous across the wrap from entry 5 to entry 0.
REQ-040 SHALL be verified by this directed scenario: i_flush asserted together with fetch and dispatch handshakes at count 3 -> o_count = 0 and o_disp_valid = 0 the next cycle, with nothing enqueued.
